// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state, and the fetch/memory arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arbstate_t;

endpackage

// File: rtl/fetch_mem_arb_if.sv
// Bundle between the fetch stage, the memory stage, the unified RAM and the arbiter.
interface fetch_mem_arb_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport fetch (
    output iREN, iaddr,
    input  iwait, iload
  );

  modport mem (
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload
  );

endinterface

// File: rtl/arb_perf_counters.sv
// Completion and fetch-stall counters for the arbiter; only built with FETCH_MEM_ARB_PERF_EN.
`ifdef FETCH_MEM_ARB_PERF_EN
module arb_perf_counters
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iren_i,
  input  logic  iwait_i,
  input  logic  dwait_i,
  output word_t icnt_o,
  output word_t dcnt_o,
  output word_t istall_o
);

  word_t icnt_q, dcnt_q, istall_q;

  // free-running wrap-around counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt_q   <= 32'h0;
      dcnt_q   <= 32'h0;
      istall_q <= 32'h0;
    end else begin
      icnt_q   <= icnt_q + {31'h0, ~iwait_i};
      dcnt_q   <= dcnt_q + {31'h0, ~dwait_i};
      istall_q <= istall_q + {31'h0, iren_i & iwait_i};
    end
  end

  assign icnt_o   = icnt_q;
  assign dcnt_o   = dcnt_q;
  assign istall_o = istall_q;

endmodule
`endif

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data accesses.
// Define FETCH_MEM_ARB_PERF_EN to add the icnt/dcnt/istall performance counters.
module fetch_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic CLK,
  input  logic nRST,
  fetch_mem_arb_if.arb bus
`ifdef FETCH_MEM_ARB_PERF_EN
  ,
  output word_t icnt,
  output word_t dcnt,
  output word_t istall
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arbstate_t        state_q, state_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             dreq;
  logic             acc;

  assign dreq = bus.dREN | bus.dWEN;
  assign acc  = (bus.ramstate == ACCESS);

  // Data wins unless fetch has waited out STARVE_LIMIT data completions.
  function automatic arbstate_t pick(input logic iren, input logic dq, input logic [CNT_W-1:0] cnt);
    arbstate_t res;
    if (dq && ((cnt < LIMIT) || !iren)) begin
      res = DGRANT;
    end else if (iren) begin
      res = IGRANT;
    end else begin
      res = IDLE;
    end
    return res;
  endfunction

  // state and starvation counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // next-state: a completing requester is excluded from the re-pick so it is not served twice
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      IDLE: begin
        state_d = pick(bus.iREN, dreq, scnt_q);
        if (!bus.iREN) begin
          scnt_d = '0;
        end else begin
          scnt_d = scnt_q;
        end
      end
      IGRANT: begin
        if (!bus.iREN) begin
          state_d = pick(1'b0, dreq, scnt_q);
        end else if (acc) begin
          scnt_d  = '0;
          state_d = pick(1'b0, dreq, '0);
        end else begin
          state_d = state_q;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_d = pick(bus.iREN, 1'b0, scnt_q);
        end else if (acc) begin
          if (!bus.iREN) begin
            scnt_d = '0;
          end else if (scnt_q >= LIMIT) begin
            scnt_d = LIMIT;
          end else begin
            scnt_d = scnt_q + CNT_W'(1);
          end
          state_d = pick(bus.iREN, 1'b0, scnt_d);
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        scnt_d  = '0;
      end
    endcase
  end

  // RAM strobes and stage waits; ERROR/BUSY/FREE simply hold the grant
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0;
    bus.ramstore = 32'h0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = 32'h0;
    bus.dload    = 32'h0;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (bus.iREN && acc) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end else begin
          bus.iwait = 1'b1;
        end
      end
      DGRANT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (dreq && acc) begin
          bus.dwait = 1'b0;
          bus.dload = bus.dREN ? bus.ramload : 32'h0;
        end else begin
          bus.dwait = 1'b1;
        end
      end
      default: begin
        bus.ramREN = 1'b0;
      end
    endcase
  end

`ifdef FETCH_MEM_ARB_PERF_EN
  arb_perf_counters u_perf (
    .CLK      (CLK),
    .nRST     (nRST),
    .iren_i   (bus.iREN),
    .iwait_i  (bus.iwait),
    .dwait_i  (bus.dwait),
    .icnt_o   (icnt),
    .dcnt_o   (dcnt),
    .istall_o (istall)
  );
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Self-checking bench for fetch_mem_arbiter: directed vector table, corner sequences, random vs model.
module tb_fetch_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  fetch_mem_arb_if bus();

`ifdef FETCH_MEM_ARB_PERF_EN
  word_t icnt, dcnt, istall;
`endif

  fetch_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef FETCH_MEM_ARB_PERF_EN
    ,
    .icnt   (icnt),
    .dcnt   (dcnt),
    .istall (istall)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic ir, input word_t ia, input logic dr, input logic dw,
                     input word_t da, input word_t ds, input word_t rl, input ramstate_t rs);
    @(negedge CLK);
    bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
    bus.daddr = da; bus.dstore = ds; bus.ramload = rl; bus.ramstate = rs;
    #1;
  endtask

  task automatic exp_all(input string t, input logic ren, input logic wen, input word_t addr,
                         input word_t store, input logic iw, input logic dw,
                         input word_t il, input word_t dl);
    chk({t, ".ramREN"},   bus.ramREN,   ren);
    chk({t, ".ramWEN"},   bus.ramWEN,   wen);
    chk({t, ".ramaddr"},  bus.ramaddr,  addr);
    chk({t, ".ramstore"}, bus.ramstore, store);
    chk({t, ".iwait"},    bus.iwait,    iw);
    chk({t, ".dwait"},    bus.dwait,    dw);
    chk({t, ".iload"},    bus.iload,    il);
    chk({t, ".dload"},    bus.dload,    dl);
  endtask

  // ---------------- reference model: who owns the RAM and how long fetch has waited
  int m_own;      // 0 nobody, 1 fetch, 2 data
  int m_starve;
  int unsigned m_icnt, m_dcnt, m_istall;
  bit m_ir, m_dq, m_acc;

  function automatic int choose(input bit ir, input bit dq, input int s);
    if (dq && !(ir && s >= LIMIT)) return 2;
    if (ir) return 1;
    return 0;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_own = 0; m_starve = 0; m_icnt = 0; m_dcnt = 0; m_istall = 0;
    end else begin
      m_ir  = bus.iREN;
      m_dq  = bus.dREN | bus.dWEN;
      m_acc = (bus.ramstate == ACCESS);
      if (m_own == 1 && m_ir && m_acc) m_icnt++;
      if (m_own == 2 && m_dq && m_acc) m_dcnt++;
      if (m_ir && !(m_own == 1 && m_acc)) m_istall++;
      case (m_own)
        1: begin
          if (!m_ir) m_own = choose(1'b0, m_dq, m_starve);
          else if (m_acc) begin m_starve = 0; m_own = choose(1'b0, m_dq, 0); end
        end
        2: begin
          if (!m_dq) m_own = choose(m_ir, 1'b0, m_starve);
          else if (m_acc) begin
            m_starve = m_ir ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
            m_own = choose(m_ir, 1'b0, m_starve);
          end
        end
        default: begin
          if (!m_ir) m_starve = 0;
          m_own = choose(m_ir, m_dq, m_starve);
        end
      endcase
    end
  end

  task automatic model_check(input string t);
    logic ren, wen, iw, dw;
    word_t addr, store, il, dl;
    bit acc;
    ren = 1'b0; wen = 1'b0; iw = 1'b1; dw = 1'b1;
    addr = 32'h0; store = 32'h0; il = 32'h0; dl = 32'h0;
    acc = (bus.ramstate == ACCESS);
    if (m_own == 1) begin
      ren = bus.iREN; addr = bus.iaddr;
      if (bus.iREN && acc) begin iw = 1'b0; il = bus.ramload; end
    end else if (m_own == 2) begin
      ren = bus.dREN; wen = bus.dWEN; addr = bus.daddr; store = bus.dstore;
      if ((bus.dREN || bus.dWEN) && acc) begin
        dw = 1'b0;
        dl = bus.dREN ? bus.ramload : 32'h0;
      end
    end
    exp_all(t, ren, wen, addr, store, iw, dw, il, dl);
  endtask

  // ---------------- directed vectors
  typedef struct {
    logic ir; word_t ia; logic dr; logic dw; word_t da; word_t ds; word_t rl; ramstate_t rs;
    logic e_ren; logic e_wen; word_t e_addr; word_t e_store;
    logic e_iw; logic e_dw; word_t e_il; word_t e_dl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2401_0005, FREE,   1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2401_0005, BUSY,   1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2401_0005, BUSY,   1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2401_0005, ACCESS, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h2401_0005, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2401_0005, FREE,   1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_0001, FREE,   1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_0001, BUSY,   1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_0001, ACCESS, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 32'hCAFE_0001});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, BUSY,   1'b1, 1'b0, 32'h40,  32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, ACCESS, 1'b1, 1'b0, 32'h40,  32'h0, 1'b0, 1'b1, 32'h1234_5678, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, FREE,   1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h0, 1'b0, 1'b1, 32'h104, 32'h1122_3344, 32'h55AA_55AA, FREE,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b1, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h0, 1'b0, 1'b1, 32'h104, 32'h1122_3344, 32'h55AA_55AA, ACCESS, 1'b0, 1'b1, 32'h104, 32'h1122_3344, 1'b1, 1'b0, 32'h0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 32'h0, 1'b0, 1'b0, 32'h104, 32'h1122_3344, 32'h55AA_55AA, FREE,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 1'b1, 32'h0, 32'h0});

    // reset with requests already presented
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.dWEN = 1'b0;
    bus.daddr = 32'h88; bus.dstore = 32'h99; bus.ramload = 32'hFFFF_FFFF; bus.ramstate = ACCESS;
    repeat (2) @(negedge CLK);
    #1;
    exp_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;

    foreach (tbl[i])
    begin
      cyc(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].ds, tbl[i].rl, tbl[i].rs);
      exp_all($sformatf("tbl%0d", i), tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_store,
              tbl[i].e_iw, tbl[i].e_dw, tbl[i].e_il, tbl[i].e_dl);
    end

    // fetch flush while granted: strobe drops at once, pending write takes over
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, BUSY);
    chk("flush.igrant", bus.ramREN, 1'b1);
    cyc(1'b0, 32'h80, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h0, BUSY);
    chk("flush.ren_drop", bus.ramREN, 1'b0);
    chk("flush.iwait", bus.iwait, 1'b1);
    cyc(1'b0, 32'h80, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h0, BUSY);
    exp_all("flush.dgrant", 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, 32'h0);
    cyc(1'b0, 32'h80, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h1, ACCESS);
    chk("flush.dwait", bus.dwait, 1'b0);
    chk("flush.dload", bus.dload, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
    chk("flush.idle", bus.ramWEN, 1'b0);

    // starvation: four data completions with fetch pending, then fetch is forced ahead of the fifth write
    cyc(1'b1, 32'hA0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h0, FREE);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'hA0, 1'b0, 1'b1, 32'h300 + k, k, 32'h0, ACCESS);
      chk($sformatf("starve.d%0d_wen", k), bus.ramWEN, 1'b1);
      chk($sformatf("starve.d%0d_dwait", k), bus.dwait, 1'b0);
      cyc(1'b0, 32'hA0, 1'b0, (k < 3) ? 1'b1 : 1'b0, 32'h301 + k, k + 1, 32'h0, BUSY);
      chk($sformatf("starve.f%0d_ren", k), bus.ramREN, 1'b0);
    end
    chk("starve.scnt", dut.scnt_q, 32'd4);
    cyc(1'b1, 32'hA0, 1'b0, 1'b1, 32'h304, 32'h5, 32'h0, FREE);
    cyc(1'b1, 32'hA0, 1'b0, 1'b1, 32'h304, 32'h5, 32'h7777, ACCESS);
    exp_all("starve.iforced", 1'b1, 1'b0, 32'hA0, 32'h0, 1'b0, 1'b1, 32'h7777, 32'h0);
    cyc(1'b0, 32'hA0, 1'b0, 1'b1, 32'h304, 32'h5, 32'h0, ACCESS);
    exp_all("starve.d5", 1'b0, 1'b1, 32'h304, 32'h5, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);

    // asynchronous reset in the middle of a data grant
    cyc(1'b1, 32'hC0, 1'b0, 1'b1, 32'h500, 32'h77, 32'h0, FREE);
    cyc(1'b1, 32'hC0, 1'b0, 1'b1, 32'h500, 32'h77, 32'h0, ACCESS);
    chk("rst.pre_dwait", bus.dwait, 1'b0);
    cyc(1'b0, 32'hC0, 1'b0, 1'b1, 32'h504, 32'h78, 32'h0, BUSY);
    cyc(1'b0, 32'hC0, 1'b0, 1'b1, 32'h504, 32'h78, 32'h0, BUSY);
    chk("rst.pre_wen", bus.ramWEN, 1'b1);
    chk("rst.pre_scnt", dut.scnt_q, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    exp_all("rst.mid", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
    @(negedge CLK);
    bus.iREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
    nRST = 1'b1;
    #1;
    chk("rst.state", 32'(dut.state_q), 32'(IDLE));
    chk("rst.scnt", dut.scnt_q, 32'd0);

    // ERROR is retried with the grant held
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hA5A5_0F0F, FREE);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hA5A5_0F0F, ERROR);
      exp_all($sformatf("err%0d", k), 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hA5A5_0F0F, ACCESS);
    exp_all("err.done", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0, 32'hA5A5_0F0F);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA5A5_0F0F, FREE);
    chk("err.idle_dload", bus.dload, 32'h0);

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      cyc(($urandom_range(0, 3) != 0), $urandom, (sel == 1), (sel == 2), $urandom, $urandom,
          $urandom, ramstate_t'($urandom_range(0, 3)));
      model_check($sformatf("rnd%0d", n));
    end

`ifdef FETCH_MEM_ARB_PERF_EN
    @(negedge CLK);
    #1;
    chk("perf.icnt", icnt, m_icnt);
    chk("perf.dcnt", dcnt, m_dcnt);
    chk("perf.istall", istall, m_istall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares the single-ported unified RAM between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Grants are held for the whole RAM transaction; data requests have priority.
- A starvation counter guarantees forward progress for instruction fetch.
- Produces the ihit-side wait consumed by the fetch interface and the dhit-side wait consumed by the memory stage.

Parameters:
- STARVE_LIMIT, 4, max consecutive data completions while iREN is pending before fetch is forced a grant (1..7).
- CNT_W, 3, starvation counter width; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request (held until iwait=0)
- iaddr  input  32  instruction address (word_t)
- dREN  input  1  data read request
- dWEN  input  1  data write request (dREN & dWEN never both 1)
- daddr  input  32  data address (word_t)
- dstore  input  32  data write value (word_t)
- ramload  input  32  RAM read data (word_t)
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- iwait  output  1  0 only in the cycle an instruction read completes
- dwait  output  1  0 only in the cycle a data access completes
- iload  output  32  ramload on instruction completion, else 0
- dload  output  32  ramload on data-read completion, else 0
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data

Behaviour:
- Clock/reset: single clock CLK; reset nRST is asynchronous, active-low.
- States: IDLE, IGRANT, DGRANT. The state register and starvation counter scnt are the only flops.
- Reset (async, any time, including mid-transaction):
  - state=IDLE, scnt=0.
  - Outputs immediately: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
- Arbitration rule (pick):
  - data wins if (dREN|dWEN) and (scnt<STARVE_LIMIT or !iREN);
  - else instruction wins if iREN;
  - else IDLE.
- IDLE: RAM strobes 0. Next state = pick. Arbitration latency is 1 cycle: a request at cycle t drives the RAM at t+1.
- IGRANT:
  - ramREN=iREN, ramaddr=iaddr.
  - Complete when ramstate==ACCESS: iwait=0, iload=ramload, scnt cleared. Next state = pick with iREN treated as 0, giving back-to-back service with no idle cycle.
- DGRANT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - Complete when ramstate==ACCESS: dwait=0, dload=ramload if dREN else 0. scnt increments (saturating at STARVE_LIMIT) if iREN=1, else clears. Next state = pick with dREN/dWEN treated as 0.
- BUSY/FREE during a grant: hold the grant; waits stay 1.
- ERROR: treated as BUSY, i.e. retry with the grant held. No completion is reported.
- Withdrawn request: if the granted requester's request drops before ACCESS (e.g. a fetch flush on a taken branch), its strobes drop combinationally. The next state is pick in the same cycle, and scnt is unchanged.
- Any cycle iREN=0 while in IDLE clears scnt.
- Waits are combinational from the registered state and ramstate. There is no combinational path from iREN/dREN to iwait/dwait other than through the strobes.

Optional Feature:
- Macro: FETCH_MEM_ARB_PERF_EN.
- When defined, adds three 32-bit outputs, cleared by reset and wrapping on overflow:
  - icnt: instruction completions.
  - dcnt: data completions.
  - istall: cycles with iREN=1 and iwait=1.
- Without it, these ports and their counters do not exist. Arbitration behaviour is identical in both cases.

Decomposition:
- Reuse word_t and ramstate_t from cpu_types_pkg.
- Add arbstate_t (IDLE, IGRANT, DGRANT) to cpu_types_pkg.
- Add a new interface fetch_mem_arb_if with modports arb, fetch and mem.
- The starvation counter is inline. The optional perf counters form one natural sub-module, arb_perf_counters.

Test Plan:
- Instruction only: iREN=1, iaddr=0x0000_0040, ramstate BUSY 2 cycles then ACCESS, ramload=0x2401_0005 -> ramREN=1 from cycle 1; iwait=0 and iload=0x2401_0005 at cycle 3 only.
- Simultaneous requests: iREN=1 and dREN=1 at reset exit, daddr=0x100 -> data granted first (ramaddr=0x100); the instruction is granted the cycle after data ACCESS with no idle gap.
- Starvation, STARVE_LIMIT=4: iREN held, five back-to-back data writes with immediate ACCESS -> 4 data completions, then an instruction grant, then the 5th write.
- Flush: IGRANT with BUSY, iREN drops -> ramREN=0 in the same cycle; a pending dWEN (daddr=0x200, dstore=0xDEAD_BEEF) is granted the next cycle.
- Reset mid-DGRANT: nRST low asynchronously -> ramWEN=0, dwait=1 before the next edge; after release, state IDLE and scnt=0.
- ERROR retry: ramstate ERROR 3 cycles then ACCESS on a dREN -> dwait stays 1 for 3 cycles, then dwait=0 with dload=ramload.
